// File: rtl/deskew_collector.sv
// Re-aligns the staggered column outputs of the 4x4 systolic array into a row-aligned
// result tile and presents it with a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; no tile held
// COLLECT | capturing staggered column values, k = 1..6
// HOLD    | tile complete, out_valid high until out_ready
module deskew_collector #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ACC_WIDTH-1:0]    col1_val,
   input  logic [ACC_WIDTH-1:0]    col2_val,
   input  logic [ACC_WIDTH-1:0]    col3_val,
   input  logic [ACC_WIDTH-1:0]    col4_val,
   output logic                    busy,
   output logic [16*ACC_WIDTH-1:0] result,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t               state;
   logic [2:0]           k;
   logic [ACC_WIDTH-1:0] col_val [4];
   logic                 accept;
   logic                 cap_en;
   logic [2:0]           cap_k;

   assign col_val[0] = col1_val;
   assign col_val[1] = col2_val;
   assign col_val[2] = col3_val;
   assign col_val[3] = col4_val;

   // A start in HOLD with out_ready hands off the old tile in the same cycle.
   assign accept = start && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));

   always_comb begin
      cap_en = 1'b0;
      cap_k  = 3'd0;
      if (state == S_COLLECT) begin
         cap_en = 1'b1;
         cap_k  = k;
      end else if (accept) begin
         cap_en = 1'b1;
         cap_k  = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         k         <= 3'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (start && !accept)
            overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  k     <= 3'd1;
                  state <= S_COLLECT;
                  busy  <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (k < 3'd6) begin
                  k <= k + 3'd1;
               end else begin
                  k         <= 3'd0;
                  state     <= S_HOLD;
                  out_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     k     <= 3'd1;
                     state <= S_COLLECT;
                  end else begin
                     k     <= 3'd0;
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               k         <= 3'd0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Element (r,j) is loaded when column j carries row r, i.e. at count k = r + j.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar j = 0; j < 4; j++) begin : g_col
         logic [ACC_WIDTH-1:0] elem;

         always_ff @(posedge clk) begin
            if (reset)
               elem <= '0;
            else if (cap_en && (cap_k == 3'(r + j)))
               elem <= col_val[j];
         end

         assign result[(4*r+j)*ACC_WIDTH +: ACC_WIDTH] = elem;
      end
   end

endmodule

// File: tb/tb_deskew_collector.sv
// Directed and randomized bench for deskew_collector; expected tiles come from a record
// of every value driven on each column, indexed by cycle.
module tb_deskew_collector;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] col1_val = '0, col2_val = '0, col3_val = '0, col4_val = '0;
   logic          busy;
   logic [16*AW-1:0] result;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit pat_en = 1'b0;
   int pat_t = 0;
   logic [AW-1:0] hist [0:2047][0:3];

   deskew_collector #(.WIDTH(8), .ACC_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .col1_val(col1_val), .col2_val(col2_val), .col3_val(col3_val), .col4_val(col4_val),
      .busy(busy), .result(result), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [16*AW-1:0] obs, input logic [16*AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, record column values, advance past the next edge.
   task automatic drive(input bit s, input bit rdy, input bit rst);
      logic [AW-1:0] v [4];
      for (int j = 0; j < 4; j++) begin
         if (pat_en) begin
            int rr;
            rr = (cyc - pat_t) - j;
            v[j] = (rr >= 0 && rr <= 3) ? AW'(10*rr + j) : 18'h3FFFF;
         end else begin
            v[j] = AW'($urandom);
         end
         hist[cyc][j] = v[j];
      end
      start = s; out_ready = rdy; reset = rst;
      col1_val = v[0]; col2_val = v[1]; col3_val = v[2]; col4_val = v[3];
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Element (r,j) must equal what column j carried at cycle t0+r+j.
   task automatic check_tile(input string tag, input int t0);
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 4; j++)
            chk($sformatf("%s_e%0d%0d", tag, r, j), (16*AW)'(result[(4*r+j)*AW +: AW]),
                (16*AW)'(hist[t0+r+j][j]));
   endtask

   // Start a tile at the current cycle and run to its first out_valid cycle.
   task automatic do_tile(input string tag, input bit first_ready, input int ovr_i, output int t0);
      t0 = cyc;
      for (int i = 0; i < 7; i++) begin
         drive((i == 0) || (i == ovr_i), (i == 0) ? first_ready : 1'b0, 1'b0);
         chk($sformatf("%s_busy%0d", tag, i), (16*AW)'(busy), (16*AW)'(1));
         chk($sformatf("%s_valid%0d", tag, i), (16*AW)'(out_valid), (16*AW)'(i == 6));
      end
      check_tile(tag, t0);
   endtask

   initial begin
      int t0, t1, w;
      bit b2b;

      // 1 reset and idle
      drive(0, 0, 1);
      drive(0, 0, 1);
      chk("rst_result", result, '0);
      chk("rst_valid", (16*AW)'(out_valid), '0);
      chk("rst_busy", (16*AW)'(busy), '0);
      chk("rst_overrun", (16*AW)'(overrun), '0);
      for (int i = 0; i < 3; i++) begin
         drive(0, $urandom_range(0, 1), 0);
         chk("idle_result", result, '0);
         chk("idle_valid", (16*AW)'(out_valid), '0);
         chk("idle_busy", (16*AW)'(busy), '0);
      end

      // 2 single tile with the patterned columns
      pat_en = 1'b1; pat_t = cyc;
      do_tile("single", 0, -1, t0);
      pat_en = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 4; j++)
            chk("single_pat", (16*AW)'(result[(4*r+j)*AW +: AW]), (16*AW)'(10*r + j));
      drive(0, 1, 0);
      chk("single_rel_valid", (16*AW)'(out_valid), '0);
      chk("single_rel_busy", (16*AW)'(busy), '0);

      // 3 back-pressure
      do_tile("bp", 0, -1, t0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0);
         chk("bp_valid", (16*AW)'(out_valid), (16*AW)'(1));
         chk("bp_busy", (16*AW)'(busy), (16*AW)'(1));
         check_tile("bp_hold", t0);
      end
      drive(0, 1, 0);
      chk("bp_rel_valid", (16*AW)'(out_valid), '0);
      chk("bp_rel_busy", (16*AW)'(busy), '0);

      // 4 back-to-back handoff
      do_tile("b2b_a", 0, -1, t0);
      do_tile("b2b_b", 1, -1, t1);
      chk("b2b_overrun", (16*AW)'(overrun), '0);
      drive(0, 1, 0);
      chk("b2b_rel_busy", (16*AW)'(busy), '0);

      // 5 ignored start mid-tile
      do_tile("ovr", 0, 3, t0);
      chk("ovr_flag", (16*AW)'(overrun), (16*AW)'(1));
      drive(0, 1, 0);
      chk("ovr_rel_busy", (16*AW)'(busy), '0);
      chk("ovr_rel_valid", (16*AW)'(out_valid), '0);
      drive(0, 0, 0);
      chk("ovr_sticky", (16*AW)'(overrun), (16*AW)'(1));
      chk("ovr_idle_busy", (16*AW)'(busy), '0);

      // 6 reset in the middle of a tile
      drive(1, 0, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
      drive(0, 0, 1);
      chk("mrst_result", result, '0);
      chk("mrst_valid", (16*AW)'(out_valid), '0);
      chk("mrst_busy", (16*AW)'(busy), '0);
      chk("mrst_overrun", (16*AW)'(overrun), '0);
      do_tile("mrst_fresh", 0, -1, t0);
      drive(0, 1, 0);

      // randomized sequence of tiles with random back-pressure and handoffs
      do_tile("rnd_first", 0, -1, t0);
      for (int n = 0; n < 6; n++) begin
         w = $urandom_range(0, 3);
         for (int i = 0; i < w; i++) begin
            drive(0, 0, 0);
            chk("rnd_hold_valid", (16*AW)'(out_valid), (16*AW)'(1));
            check_tile("rnd_hold", t0);
         end
         b2b = 1'($urandom_range(0, 1));
         if (b2b) begin
            do_tile("rnd_b2b", 1, -1, t0);
         end else begin
            drive(0, 1, 0);
            chk("rnd_rel_valid", (16*AW)'(out_valid), '0);
            chk("rnd_rel_busy", (16*AW)'(busy), '0);
            w = $urandom_range(0, 2);
            for (int i = 0; i < w; i++) drive(0, $urandom_range(0, 1), 0);
            do_tile("rnd_tile", 0, -1, t0);
         end
         chk("rnd_overrun", (16*AW)'(overrun), '0);
      end
      drive(0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
